// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter at the head of instruction fetch.
// Each clock the PC either advances by 4, takes a PC-relative branch, takes
// a region jump, or takes a register jump. A circular return-address stack
// (RAS) records call return addresses, and returns pop them.
// Optional build macro PC_ALIGN_CHECK_EN: a misaligned register-jump target
// redirects to TRAP_VEC and pulses misalign for one cycle. Without the
// macro, the low two bits of the target are cleared and misalign is tied 0.
`default_nettype none

module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = 'h80
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          branch,
    input  logic                          zero,
    input  logic                          jump,
    input  logic                          jr,
    input  logic                          link,
    input  logic                          ret,
    input  logic [ADDR_W-1:0]             imm_ext,
    input  logic [ADDR_W-7:0]             j_addr,
    input  logic [ADDR_W-1:0]             reg_target,
    output logic [ADDR_W-1:0]             pc,
    output logic [ADDR_W-1:0]             pc_plus4,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          misalign
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    // ptr_q is the slot the next push writes; the top of stack is ptr_q-1.
    logic [PTR_W-1:0]  ptr_q, ptr_d, top_ptr, wr_ptr;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ras_empty, ras_full;
    logic              jr_sel, pop, push;
    logic [ADDR_W-1:0] ras_top, jr_raw, jump_target, br_target;

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign ras_count = cnt_q;

    assign top_ptr   = ptr_q - PTR_W'(1);
    assign ras_top   = ras_q[top_ptr];
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == DEPTH_CNT);

    // A jump outranks jr, so a return only pops when the jr path is the one
    // actually taken; otherwise the saved return address would be lost.
    assign jr_sel = jr && !jump;
    assign pop    = !stall && jr_sel && ret && !ras_empty;
    assign push   = !stall && (jump || jr) && link;

    assign jr_raw      = pop ? ras_top : reg_target;
    assign jump_target = {pc_plus4[ADDR_W-1:ADDR_W-4], j_addr, 2'b00};
    assign br_target   = pc_plus4 + (imm_ext << 2);

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign misalign = misalign_q;
`else
    logic unused_align;
    assign misalign     = 1'b0;
    assign unused_align = ^{TRAP_VEC, jr_raw[1:0]};
`endif

    // Next-PC selection in fixed priority: jump, jr (pop or register), branch, +4.
    always_comb begin
        pc_d = pc_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        if (!stall) begin
            if (jump) begin
                pc_d = jump_target;
            end else if (jr) begin
`ifdef PC_ALIGN_CHECK_EN
                if (jr_raw[1:0] != 2'b00) begin
                    pc_d       = TRAP_VEC;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = jr_raw;
                end
`else
                pc_d = {jr_raw[ADDR_W-1:2], 2'b00};
`endif
            end else if (branch && zero) begin
                pc_d = br_target;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // RAS bookkeeping: pop+push rewrites the top in place, a full push wraps
    // over the oldest entry while the count saturates at RAS_DEPTH.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_ptr = ptr_q;
        if (pop && push) begin
            wr_ptr = top_ptr;
        end else if (pop) begin
            ptr_d = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!ras_full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // PC and RAS control registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // RAS storage; contents need no reset because cnt_q gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_q[wr_ptr] <= pc_plus4;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // One-cycle trap pulse; cleared by reset and by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

endmodule

`default_nettype wire
